control_ranas_n: RTL and testbench
==================================

Name: control_ranas_n

Overview:
Parametrised frog-round controller for the Frogger game core. It tracks how many frogs have reached the home row and which goal slots are taken, and it keeps a lives counter. It tells the frog-position block when to re-spawn the frog. It ends the game with a one-cycle win or game-over pulse, which the game-state FSM consumes.

Parameters:
DATAWIDTH_POS, 3, width of frog X/Y coordinates
DATAWIDTH_ESTADO, 3, width of game-state input
ESTADO_JUEGO, 3'b111, value of CRN_ESTADO that starts/sustains play
META_Y, 3'b111, Y coordinate of the home row
META_MASK, 8'b0101_0010, goal-column bitmap; bit i=1 means column i is a goal (width 2**DATAWIDTH_POS)
NUM_RANAS, 3, frogs needed to win (1..popcount(META_MASK))
NUM_VIDAS, 3, lives per game (1..2**VIDA_W-1)
CNT_W, 4, width of frog counter
VIDA_W, 2, width of lives counter

Ports:
CRN_CLOCK_50  in  1  system clock, all state on rising edge
CRN_RESET  in  1  synchronous active-high reset
CRN_POSX  in  DATAWIDTH_POS  frog X position
CRN_POSY  in  DATAWIDTH_POS  frog Y position
CRN_PERDIO  in  1  collision/death indication from hazard logic
CRN_ESTADO  in  DATAWIDTH_ESTADO  game state from main FSM
CRN_RANA_INI_OUT  out  1  frog re-spawn request (position block loads start position)
CRN_GANO_OUT  out  1  one-cycle win pulse
CRN_FIN_OUT  out  1  one-cycle game-over pulse
CRN_RANAS_OUT  out  CNT_W  frogs home this game
CRN_VIDAS_OUT  out  VIDA_W  lives remaining
CRN_META_OCUP_OUT  out  2**DATAWIDTH_POS  goal occupancy bitmap

Behaviour:
- Reset (synchronous, overrides all, including mid-game): state=IDLE, RANAS=0, VIDAS=NUM_VIDAS, META_OCUP=0.
- Pulse/request outputs are Moore decodes of the state register. Counters and bitmap are registers.
- Define LLEGADA = POSY==META_Y & META_MASK[POSX] & !META_OCUP[POSX].
- Define MALA_META = POSY==META_Y & !LLEGADA (non-goal column or occupied goal).
- States and outputs (RANA_INI/GANO/FIN):
  - IDLE 1/0/0
  - INI_RANA 1/0/0
  - JUGANDO 0/0/0
  - LLEGO 0/0/0
  - MUERTE 0/0/0
  - GANO 0/1/0
  - FIN 0/0/1
- IDLE: if ESTADO==ESTADO_JUEGO, go to INI_RANA and on the same edge clear RANAS/META_OCUP and load VIDAS=NUM_VIDAS. Otherwise hold. Counters keep last-game values while idle, for display.
- INI_RANA: exactly one cycle, then JUGANDO. If ESTADO!=ESTADO_JUEGO, go to IDLE instead.
- JUGANDO: priority is abort > LLEGADA > (PERDIO | MALA_META) > hold.
  - abort (ESTADO!=ESTADO_JUEGO): go to IDLE, counters held.
  - LLEGADA: go to LLEGO, set META_OCUP[POSX], RANAS+1 on the same edge.
  - PERDIO or MALA_META: go to MUERTE, VIDAS-1 on the same edge.
  - A valid arrival coincident with PERDIO counts as an arrival.
- LLEGO: one cycle. If RANAS==NUM_RANAS go to GANO, else go to INI_RANA.
- MUERTE: one cycle. If VIDAS==0 go to FIN, else go to INI_RANA.
- GANO and FIN: one cycle each, then IDLE.
- Latency: arrival sampled at edge k gives RANAS updated after k and RANA_INI high after k+1. On the final frog, GANO_OUT is high after k+1 for exactly one cycle.
- Saturation: RANAS never exceeds NUM_RANAS and VIDAS never underflows, because the FSM exits first. The RTL still guards both counters.
- A goal slot already set is never cleared until the next game start or reset.
- Undefined state encodings recover to IDLE on the next edge.

Test Plan:
1. Assert reset, then release with ESTADO=0 -> RANA_INI=1, GANO=FIN=0, RANAS=0, VIDAS=3, META_OCUP=0x00, state stays IDLE.
2. ESTADO=7, then frog at (1,7), (4,7), (6,7), each after a respawn -> RANAS 1,2,3; META_OCUP 0x02, 0x12, 0x52; single-cycle GANO pulse one cycle after the third arrival; then IDLE with RANA_INI=1.
3. Arrival at (4,7), then again at (4,7) -> second event is a death: RANAS=1, VIDAS 3->2, META_OCUP=0x10, RANA_INI pulses for one cycle.
4. Frog at (2,7) (non-goal) -> MUERTE, VIDAS=2, RANAS unchanged; three such deaths -> VIDAS=0 and single-cycle FIN pulse.
5. PERDIO=1 on the same cycle the frog is at (6,7) -> counted as arrival: RANAS+1, VIDAS unchanged.
6. Reset asserted in JUGANDO with RANAS=2 -> next edge IDLE, RANAS=0, VIDAS=3, META_OCUP=0. ESTADO dropping to 0 in JUGANDO -> IDLE with counters held.

Source files
------------

// File: rtl/control_ranas_n.sv
// Frog-round controller: counts frogs home, tracks goal slots and lives, and
// requests re-spawns; ends each game with a one-cycle win or game-over pulse.
module control_ranas_n #(
   parameter int unsigned DATAWIDTH_POS    = 3,
   parameter int unsigned DATAWIDTH_ESTADO = 3,
   parameter logic [DATAWIDTH_ESTADO-1:0] ESTADO_JUEGO = 3'b111,
   parameter logic [DATAWIDTH_POS-1:0]    META_Y       = 3'b111,
   parameter logic [2**DATAWIDTH_POS-1:0] META_MASK    = 8'b0101_0010,
   parameter int unsigned NUM_RANAS = 3,
   parameter int unsigned NUM_VIDAS = 3,
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned VIDA_W    = 2
) (
   input  logic                          CRN_CLOCK_50,
   input  logic                          CRN_RESET,
   input  logic [DATAWIDTH_POS-1:0]      CRN_POSX,
   input  logic [DATAWIDTH_POS-1:0]      CRN_POSY,
   input  logic                          CRN_PERDIO,
   input  logic [DATAWIDTH_ESTADO-1:0]   CRN_ESTADO,
   output logic                          CRN_RANA_INI_OUT,
   output logic                          CRN_GANO_OUT,
   output logic                          CRN_FIN_OUT,
   output logic [CNT_W-1:0]              CRN_RANAS_OUT,
   output logic [VIDA_W-1:0]             CRN_VIDAS_OUT,
   output logic [2**DATAWIDTH_POS-1:0]   CRN_META_OCUP_OUT
);

   typedef enum logic [2:0] {
      StIdle, StIniRana, StJugando, StLlego, StMuerte, StGano, StFin
   } state_t;

   state_t state_q, state_d;
   logic [CNT_W-1:0]            ranas_q, ranas_d;
   logic [VIDA_W-1:0]           vidas_q, vidas_d;
   logic [2**DATAWIDTH_POS-1:0] meta_q, meta_d;

   logic jugar, en_meta, llegada, mala_meta;

   assign jugar     = (CRN_ESTADO == ESTADO_JUEGO);
   assign en_meta   = (CRN_POSY == META_Y);
   assign llegada   = en_meta && META_MASK[CRN_POSX] && !meta_q[CRN_POSX];
   // Home row but not a free goal: wrong column or an already taken slot.
   assign mala_meta = en_meta && !llegada;

   always_ff @(posedge CRN_CLOCK_50) begin
      if (CRN_RESET) begin
         state_q <= StIdle;
         ranas_q <= '0;
         vidas_q <= VIDA_W'(NUM_VIDAS);
         meta_q  <= '0;
      end else begin
         state_q <= state_d;
         ranas_q <= ranas_d;
         vidas_q <= vidas_d;
         meta_q  <= meta_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      ranas_d          = ranas_q;
      vidas_d          = vidas_q;
      meta_d           = meta_q;
      CRN_RANA_INI_OUT = 1'b0;
      CRN_GANO_OUT     = 1'b0;
      CRN_FIN_OUT      = 1'b0;
      case (state_q)
         StIdle: begin
            CRN_RANA_INI_OUT = 1'b1;
            if (jugar) begin
               state_d = StIniRana;
               ranas_d = '0;
               vidas_d = VIDA_W'(NUM_VIDAS);
               meta_d  = '0;
            end
         end
         StIniRana: begin
            CRN_RANA_INI_OUT = 1'b1;
            state_d = jugar ? StJugando : StIdle;
         end
         StJugando: begin
            if (!jugar) begin
               state_d = StIdle;
            end else if (llegada) begin
               state_d          = StLlego;
               meta_d[CRN_POSX] = 1'b1;
               if (ranas_q < CNT_W'(NUM_RANAS)) ranas_d = ranas_q + CNT_W'(1);
            end else if (CRN_PERDIO || mala_meta) begin
               state_d = StMuerte;
               if (vidas_q != '0) vidas_d = vidas_q - VIDA_W'(1);
            end
         end
         StLlego:  state_d = (ranas_q == CNT_W'(NUM_RANAS)) ? StGano : StIniRana;
         StMuerte: state_d = (vidas_q == '0) ? StFin : StIniRana;
         StGano: begin
            CRN_GANO_OUT = 1'b1;
            state_d      = StIdle;
         end
         StFin: begin
            CRN_FIN_OUT = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign CRN_RANAS_OUT     = ranas_q;
   assign CRN_VIDAS_OUT     = vidas_q;
   assign CRN_META_OCUP_OUT = meta_q;

endmodule

// File: tb/tb_control_ranas_n.sv
// Bench for control_ranas_n: directed vector table, a reset corner sequence and
// randomized play checked against a schedule-based reference model.
module tb_control_ranas_n;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] estado, posx, posy;
   logic       perdio;
   logic       rana_ini, gano, fin;
   logic [3:0] ranas;
   logic [1:0] vidas;
   logic [7:0] meta;

   control_ranas_n dut (
      .CRN_CLOCK_50      (clk),
      .CRN_RESET         (rst),
      .CRN_POSX          (posx),
      .CRN_POSY          (posy),
      .CRN_PERDIO        (perdio),
      .CRN_ESTADO        (estado),
      .CRN_RANA_INI_OUT  (rana_ini),
      .CRN_GANO_OUT      (gano),
      .CRN_FIN_OUT       (fin),
      .CRN_RANAS_OUT     (ranas),
      .CRN_VIDAS_OUT     (vidas),
      .CRN_META_OCUP_OUT (meta)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] pulses, input int r,
                            input int v, input logic [7:0] m);
      check({tag, " rana_ini"}, {7'd0, rana_ini}, {7'd0, pulses[2]});
      check({tag, " gano"},     {7'd0, gano},     {7'd0, pulses[1]});
      check({tag, " fin"},      {7'd0, fin},      {7'd0, pulses[0]});
      check({tag, " ranas"},    {4'd0, ranas},    8'(r));
      check({tag, " vidas"},    {6'd0, vidas},    8'(v));
      check({tag, " meta"},     meta,             m);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [2:0] e, input logic [2:0] x,
                        input logic [2:0] y, input logic p);
      rst = r; estado = e; posx = x; posy = y; perdio = p;
   endtask

   // Directed vectors: inputs applied before an edge, outputs expected after it.
   typedef struct {
      logic       r;
      logic [2:0] e, x, y;
      logic       p;
      logic [2:0] pulses;  // {rana_ini, gano, fin}
      int         rn, vd;
      logic [7:0] m;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input logic r, input logic [2:0] e, input logic [2:0] x,
                               input logic [2:0] y, input logic p, input logic [2:0] pl,
                               input int rn, input int vd, input logic [7:0] m);
      vec_t v;
      v.r = r; v.e = e; v.x = x; v.y = y; v.p = p; v.pulses = pl;
      v.rn = rn; v.vd = vd; v.m = m;
      vecs.push_back(v);
   endfunction

   // Reference model: a queue of the forced single-cycle phases still to come,
   // plus whether the frog is playable once the queue drains.
   typedef struct { logic [2:0] pulses; bit abortable; } ph_t;
   ph_t        sched[$];
   bit         live;
   int         m_ranas, m_vidas;
   logic [7:0] m_meta;
   logic [7:0] mask = 8'h52;

   function automatic void push(input logic [2:0] pl, input bit ab);
      ph_t ph;
      ph.pulses = pl; ph.abortable = ab;
      sched.push_back(ph);
   endfunction

   task automatic model_step();
      ph_t h;
      bit  goal;
      if (rst) begin
         sched.delete(); live = 0; m_ranas = 0; m_vidas = 3; m_meta = '0;
      end else if (sched.size() > 0) begin
         h = sched.pop_front();
         if (h.abortable && estado != 3'd7) begin
            sched.delete(); live = 0;
         end
      end else if (!live) begin
         if (estado == 3'd7) begin
            m_ranas = 0; m_vidas = 3; m_meta = '0;
            push(3'b100, 1); live = 1;
         end
      end else if (estado != 3'd7) begin
         live = 0;
      end else begin
         goal = (posy == 3'd7) && mask[posx] && !m_meta[posx];
         if (goal) begin
            m_meta[posx] = 1'b1;
            m_ranas++;
            push(3'b000, 0);
            if (m_ranas == 3) begin push(3'b010, 0); live = 0; end
            else push(3'b100, 1);
         end else if (perdio || posy == 3'd7) begin
            m_vidas--;
            push(3'b000, 0);
            if (m_vidas == 0) begin push(3'b001, 0); live = 0; end
            else push(3'b100, 1);
         end
      end
   endtask

   function automatic logic [2:0] model_pulses();
      if (sched.size() > 0) return sched[0].pulses;
      return live ? 3'b000 : 3'b100;
   endfunction

   initial begin
      // Reset and idle
      add(1,0,0,0,0,3'b100,0,3,8'h00);
      add(0,0,0,0,0,3'b100,0,3,8'h00);
      // Win: arrivals at columns 1, 4, 6
      add(0,7,0,0,0,3'b100,0,3,8'h00);
      add(0,7,0,0,0,3'b000,0,3,8'h00);
      add(0,7,1,7,0,3'b000,1,3,8'h02);
      add(0,7,0,0,0,3'b100,1,3,8'h02);
      add(0,7,0,0,0,3'b000,1,3,8'h02);
      add(0,7,4,7,0,3'b000,2,3,8'h12);
      add(0,7,0,0,0,3'b100,2,3,8'h12);
      add(0,7,0,0,0,3'b000,2,3,8'h12);
      add(0,7,6,7,0,3'b000,3,3,8'h52);
      add(0,7,0,0,0,3'b010,3,3,8'h52);
      add(0,7,0,0,0,3'b100,3,3,8'h52);
      // New game; occupied goal is a death
      add(0,7,0,0,0,3'b100,0,3,8'h00);
      add(0,7,0,0,0,3'b000,0,3,8'h00);
      add(0,7,4,7,0,3'b000,1,3,8'h10);
      add(0,7,0,0,0,3'b100,1,3,8'h10);
      add(0,7,0,0,0,3'b000,1,3,8'h10);
      add(0,7,4,7,0,3'b000,1,2,8'h10);
      add(0,7,0,0,0,3'b100,1,2,8'h10);
      add(0,7,0,0,0,3'b000,1,2,8'h10);
      // Non-goal column deaths down to game over
      add(0,7,2,7,0,3'b000,1,1,8'h10);
      add(0,7,0,0,0,3'b100,1,1,8'h10);
      add(0,7,0,0,0,3'b000,1,1,8'h10);
      add(0,7,2,7,0,3'b000,1,0,8'h10);
      add(0,7,0,0,0,3'b001,1,0,8'h10);
      add(0,0,0,0,0,3'b100,1,0,8'h10);
      add(0,0,0,0,0,3'b100,1,0,8'h10);
      // Arrival coincident with PERDIO counts as arrival
      add(0,7,0,0,0,3'b100,0,3,8'h00);
      add(0,7,0,0,0,3'b000,0,3,8'h00);
      add(0,7,6,7,1,3'b000,1,3,8'h40);
      add(0,7,0,0,0,3'b100,1,3,8'h40);
      add(0,7,0,0,0,3'b000,1,3,8'h40);
      add(0,7,0,0,1,3'b000,1,2,8'h40);
      add(0,7,0,0,0,3'b100,1,2,8'h40);
      add(0,7,0,0,0,3'b000,1,2,8'h40);
      // Reset mid-game with two frogs home
      add(0,7,1,7,0,3'b000,2,2,8'h42);
      add(0,7,0,0,0,3'b100,2,2,8'h42);
      add(0,7,0,0,0,3'b000,2,2,8'h42);
      add(1,7,0,0,0,3'b100,0,3,8'h00);
      add(0,0,0,0,0,3'b100,0,3,8'h00);
      // Abort from play holds counters; abort from re-spawn
      add(0,7,0,0,0,3'b100,0,3,8'h00);
      add(0,7,0,0,0,3'b000,0,3,8'h00);
      add(0,7,1,7,0,3'b000,1,3,8'h02);
      add(0,7,0,0,0,3'b100,1,3,8'h02);
      add(0,7,0,0,0,3'b000,1,3,8'h02);
      add(0,0,0,0,0,3'b100,1,3,8'h02);
      add(0,0,0,0,0,3'b100,1,3,8'h02);
      add(0,7,0,0,0,3'b100,0,3,8'h00);
      add(0,0,0,0,0,3'b100,0,3,8'h00);
      add(0,0,0,0,0,3'b100,0,3,8'h00);

      drive(1, 0, 0, 0, 0);
      #1;
      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].e, vecs[i].x, vecs[i].y, vecs[i].p);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].pulses, vecs[i].rn, vecs[i].vd, vecs[i].m);
      end

      // Reset during the arrival cycle, then a fresh game starts cleanly
      drive(1, 0, 0, 0, 0); step();
      drive(0, 7, 0, 0, 0); step();
      step();
      drive(0, 7, 6, 7, 0); step();
      check_all("seq_llego", 3'b000, 1, 3, 8'h40);
      drive(1, 7, 0, 0, 0); step();
      check_all("seq_rst_llego", 3'b100, 0, 3, 8'h00);
      drive(0, 7, 0, 0, 0); step();
      check_all("seq_restart", 3'b100, 0, 3, 8'h00);
      step();
      drive(0, 7, 7, 7, 0); step();
      check_all("seq_col7_death", 3'b000, 0, 2, 8'h00);

      // Randomized play against the reference model
      for (int c = 0; c < 3000; c++) begin
         rst    = (c == 0) || ($urandom_range(0, 199) == 0);
         estado = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
         posx   = 3'($urandom_range(0, 7));
         posy   = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
         perdio = ($urandom_range(0, 9) == 0);
         model_step();
         step();
         check_all($sformatf("rnd%0d", c), model_pulses(), m_ranas, m_vidas, m_meta);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
